// File: rtl/dfd_cla_pkg.sv
// Shared types for the CLA debug-bus change detector: channel mode and per-channel config.
// The dfd_cr_csr_pkg register map unpacks into ChangeChCfg_s. Fields are sized for the widest instance.
package dfd_cla_pkg;

    localparam int DFD_CLA_DBG_W_MAX = 64;
    localparam int DFD_CLA_CNT_W_MAX = 16;

    typedef enum logic [1:0] {
        ANY   = 2'd0,
        RISE  = 2'd1,
        FALL  = 2'd2,
        LEVEL = 2'd3
    } ChangeMode_e;

    typedef struct packed {
        logic                         Enable;
        ChangeMode_e                  Mode;
        logic [DFD_CLA_DBG_W_MAX-1:0] Mask;
        logic [DFD_CLA_CNT_W_MAX-1:0] Threshold;
    } ChangeChCfg_s;

    // Raw (unqualified) event for one channel given the masked bus now and one cycle ago.
    function automatic logic mode_event(input ChangeMode_e mode,
                                        input logic [DFD_CLA_DBG_W_MAX-1:0] cur,
                                        input logic [DFD_CLA_DBG_W_MAX-1:0] prev);
        logic ev;
        case (mode)
            ANY:     ev = (cur != prev);
            RISE:    ev = |(cur & ~prev);
            FALL:    ev = |(~cur & prev);
            default: ev = |cur;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/dfd_cla_debug_signals_change_ch.sv
// One change-detect channel: masks the bus, detects the selected edge/level event,
// counts qualified events and pulses a match when the threshold is reached.
module dfd_cla_debug_signals_change_ch
    import dfd_cla_pkg::*;
#(
    parameter int DEBUG_SIGNALS_WIDTH = 64,
    parameter int CNT_W               = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  ChangeChCfg_s                   i_cfg,
    input  logic                           i_clear,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0] i_debug_signals,
    output logic                           o_match_nxt,
    output logic                           o_match,
    output logic [CNT_W-1:0]               o_count
);

    logic [DEBUG_SIGNALS_WIDTH-1:0] r_prev;
    logic                           r_primed;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_match;

    logic [DEBUG_SIGNALS_WIDTH-1:0] w_masked;
    logic                           w_event_raw;
    logic                           w_event_q;
    logic [CNT_W:0]                 w_cnt_inc;
    logic [CNT_W:0]                 w_thr;
    logic [CNT_W-1:0]               w_cnt_nxt;
    logic                           w_match_nxt;

    // Mask/Mode act combinationally, so a Mask change in ANY mode can raise one spurious event.
    assign w_masked    = i_debug_signals & i_cfg.Mask[DEBUG_SIGNALS_WIDTH-1:0];
    assign w_event_raw = mode_event(i_cfg.Mode,
                                    DFD_CLA_DBG_W_MAX'(w_masked),
                                    DFD_CLA_DBG_W_MAX'(r_prev));
    assign w_event_q   = w_event_raw & i_cfg.Enable & r_primed & ~i_clear;

    // One extra bit keeps count+1 from wrapping; threshold 0 is treated as 1.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_thr     = (i_cfg.Threshold[CNT_W-1:0] == '0) ? {{CNT_W{1'b0}}, 1'b1}
                                                          : {1'b0, i_cfg.Threshold[CNT_W-1:0]};

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_match_nxt = 1'b0;
        if (i_clear) begin
            w_cnt_nxt = '0;
        end else if (w_event_q) begin
            if (w_cnt_inc >= w_thr) begin
                w_cnt_nxt   = '0;
                w_match_nxt = 1'b1;
            end else begin
                w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
            end
        end
    end

    // prev always tracks the bus, so priming one cycle later never compares against stale data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_cnt    <= '0;
            r_match  <= 1'b0;
        end else begin
            r_prev   <= w_masked;
            r_primed <= i_cfg.Enable & ~i_clear;
            r_cnt    <= w_cnt_nxt;
            r_match  <= w_match_nxt;
        end
    end

    assign o_match_nxt = w_match_nxt;
    assign o_match     = r_match;
    assign o_count     = r_cnt;

    if (DEBUG_SIGNALS_WIDTH < DFD_CLA_DBG_W_MAX) begin : g_mask_pad
        logic w_unused_mask;
        assign w_unused_mask = |i_cfg.Mask[DFD_CLA_DBG_W_MAX-1:DEBUG_SIGNALS_WIDTH];
    end
    if (CNT_W < DFD_CLA_CNT_W_MAX) begin : g_thr_pad
        logic w_unused_thr;
        assign w_unused_thr = |i_cfg.Threshold[DFD_CLA_CNT_W_MAX-1:CNT_W];
    end

endmodule

// File: rtl/dfd_cla_debug_signals_change_mc.sv
// Multi-channel debug-bus change detector: NUM_CH independent channels plus a
// registered OR of all channel matches.
module dfd_cla_debug_signals_change_mc
    import dfd_cla_pkg::*;
#(
    parameter int DEBUG_SIGNALS_WIDTH = 64,
    parameter int NUM_CH              = 4,
    parameter int CNT_W               = 8
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  ChangeChCfg_s [NUM_CH-1:0]        ChCfg,
    input  logic [NUM_CH-1:0]                ch_clear,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0]   debug_signals,
    output logic [NUM_CH-1:0]                change_match,
    output logic                             change_match_any,
    output logic [NUM_CH-1:0][CNT_W-1:0]     change_count
);

    logic [NUM_CH-1:0] w_match_nxt;
    logic              r_match_any;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dfd_cla_debug_signals_change_ch #(
            .DEBUG_SIGNALS_WIDTH(DEBUG_SIGNALS_WIDTH),
            .CNT_W              (CNT_W)
        ) u_ch (
            .clock          (clock),
            .reset_n        (reset_n),
            .i_cfg          (ChCfg[c]),
            .i_clear        (ch_clear[c]),
            .i_debug_signals(debug_signals),
            .o_match_nxt    (w_match_nxt[c]),
            .o_match        (change_match[c]),
            .o_count        (change_count[c])
        );
    end

    // Built from next-state matches so it lines up with change_match.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_match_any <= 1'b0;
        end else begin
            r_match_any <= |w_match_nxt;
        end
    end

    assign change_match_any = r_match_any;

endmodule

// File: tb/tb_dfd_cla_debug_signals_change_mc.sv
// Bench for the multi-channel change detector: directed scenarios then random traffic,
// every cycle compared against an event-level reference model.
module tb_dfd_cla_debug_signals_change_mc;
    import dfd_cla_pkg::*;

    localparam int W      = 64;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                         clock = 1'b0;
    logic                         reset_n;
    ChangeChCfg_s [NUM_CH-1:0]    cfg;
    logic [NUM_CH-1:0]            clr;
    logic [W-1:0]                 bus;
    logic [NUM_CH-1:0]            change_match;
    logic                         change_match_any;
    logic [NUM_CH-1:0][CNT_W-1:0] change_count;

    dfd_cla_debug_signals_change_mc #(
        .DEBUG_SIGNALS_WIDTH(W),
        .NUM_CH             (NUM_CH),
        .CNT_W              (CNT_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ChCfg           (cfg),
        .ch_clear        (clr),
        .debug_signals   (bus),
        .change_match    (change_match),
        .change_match_any(change_match_any),
        .change_count    (change_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the outputs should show after the next edge.
    logic [W-1:0]      m_prev   [NUM_CH];
    bit                m_primed [NUM_CH];
    int                m_cnt    [NUM_CH];
    bit [NUM_CH-1:0]   m_match;
    bit                m_any;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_prev[c]   = '0;
            m_primed[c] = 0;
            m_cnt[c]    = 0;
        end
        m_match = '0;
        m_any   = 0;
    endfunction

    function automatic void model_step();
        bit any_n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [W-1:0] cur;
            bit           fire;
            int           thr;
            cur = bus & cfg[c].Mask;
            case (cfg[c].Mode)
                ANY:     fire = (cur != m_prev[c]);
                RISE:    fire = ($countones(cur & ~m_prev[c]) > 0);
                FALL:    fire = ($countones(m_prev[c] & ~cur) > 0);
                default: fire = ($countones(cur) > 0);
            endcase
            thr = int'(cfg[c].Threshold[CNT_W-1:0]);
            if (thr == 0) thr = 1;
            m_match[c] = 0;
            if (clr[c]) begin
                m_cnt[c] = 0;
            end else if (cfg[c].Enable && m_primed[c] && fire) begin
                if (m_cnt[c] + 1 >= thr) begin
                    m_cnt[c]   = 0;
                    m_match[c] = 1;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            m_primed[c] = cfg[c].Enable && !clr[c];
            m_prev[c]   = cur;
            if (m_match[c]) any_n = 1;
        end
        m_any = any_n;
    endfunction

    function automatic logic [NUM_CH*CNT_W-1:0] exp_counts();
        logic [NUM_CH*CNT_W-1:0] e;
        for (int c = 0; c < NUM_CH; c++) e[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        return e;
    endfunction

    // Inputs are set right after a negedge; this advances one clock and checks everything.
    task automatic cycle();
        model_step();
        @(negedge clock);
        chk("match", 64'(change_match), 64'(m_match));
        chk("match_any", 64'(change_match_any), 64'(m_any));
        chk("count", 64'(change_count), 64'(exp_counts()));
    endtask

    task automatic set_ch(input int c, input bit en, input ChangeMode_e m,
                          input logic [W-1:0] mask, input int thr);
        cfg[c].Enable    = en;
        cfg[c].Mode      = m;
        cfg[c].Mask      = mask;
        cfg[c].Threshold = 16'(thr);
    endtask

    int p1, p2, pm;

    initial begin
        reset_n = 1'b0;
        cfg     = '0;
        clr     = '0;
        bus     = '0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_match", 64'(change_match), 64'd0);
        chk("rst_any", 64'(change_match_any), 64'd0);
        chk("rst_count", 64'(change_count), 64'd0);

        // Single ANY channel, threshold 1: one change gives one pulse.
        reset_n = 1'b1;
        set_ch(0, 1, ANY, 64'hFF, 1);
        repeat (2) cycle();
        bus = 64'h1;
        cycle();
        chk("any_thr1_pulse", 64'(change_match[0]), 64'd1);
        chk("any_thr1_count", 64'(change_count[0]), 64'd0);
        cycle();
        chk("any_thr1_oneshot", 64'(change_match[0]), 64'd0);

        // RISE on ch1 and FALL on ch2 from the same toggling bit.
        set_ch(0, 0, ANY, 64'hFF, 1);
        set_ch(1, 1, RISE, 64'h1, 1);
        set_ch(2, 1, FALL, 64'h1, 1);
        bus = '0;
        repeat (2) cycle();
        p1 = 0; p2 = 0;
        for (int i = 0; i < 4; i++) begin
            bus = (i % 2 == 0) ? 64'h1 : 64'h0;
            cycle();
            p1 += int'(change_match[1]);
            p2 += int'(change_match[2]);
            if (i % 2 == 0) chk("rise_on_01", 64'(change_match[1]), 64'd1);
            else            chk("fall_on_10", 64'(change_match[2]), 64'd1);
        end
        chk("rise_pulses", 64'(p1), 64'd2);
        chk("fall_pulses", 64'(p2), 64'd2);

        // ANY with threshold 3 over five changes.
        set_ch(1, 0, ANY, 64'h0, 1);
        set_ch(2, 0, ANY, 64'h0, 1);
        set_ch(0, 1, ANY, 64'hFF, 3);
        repeat (2) cycle();
        pm = 0;
        for (int i = 0; i < 5; i++) begin
            bus = 64'(i + 2);
            cycle();
            pm += int'(change_match[0]);
            if (i == 2) chk("thr3_third", 64'(change_match[0]), 64'd1);
        end
        chk("thr3_pulses", 64'(pm), 64'd1);
        chk("thr3_count", 64'(change_count[0]), 64'd2);

        // Disabled for 10 cycles: count holds, no pulses.
        cfg[0].Enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus = 64'(i + 20);
            cycle();
            chk("disabled_nomatch", 64'(change_match[0]), 64'd0);
        end
        chk("disabled_frozen", 64'(change_count[0]), 64'd2);
        set_ch(0, 1, ANY, 64'hFF, 1);
        bus = 64'h40;
        cycle();
        chk("reenable_first", 64'(change_match[0]), 64'd0);
        bus = 64'h41;
        cycle();
        chk("reenable_second", 64'(change_match[0]), 64'd1);

        // Clear coincident with an event wins.
        bus = 64'h42;
        clr = 4'b0001;
        cycle();
        chk("clear_nomatch", 64'(change_match[0]), 64'd0);
        chk("clear_count", 64'(change_count[0]), 64'd0);
        clr = '0;

        // Build count to 2, then drop reset between edges.
        cfg[0].Threshold = 16'd5;
        repeat (2) cycle();
        bus = 64'h10; cycle();
        bus = 64'h11; cycle();
        chk("pre_reset_count", 64'(change_count[0]), 64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(change_count), 64'd0);
        chk("async_rst_match", 64'(change_match), 64'd0);
        chk("async_rst_any", 64'(change_match_any), 64'd0);
        model_reset();
        @(negedge clock);

        // Release with a busy bus: no match in the first two cycles.
        bus = 64'hA5;
        set_ch(0, 1, ANY, 64'hFF, 1);
        set_ch(1, 1, RISE, 64'hFF, 1);
        set_ch(2, 1, FALL, 64'hFF, 1);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("release_quiet", 64'(change_match), 64'd0);
        end

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) begin
                    logic [W-1:0] mk;
                    case ($urandom_range(0, 3))
                        0:       mk = 64'hFF;
                        1:       mk = 64'h1;
                        2:       mk = 64'hF0;
                        default: mk = {$urandom, $urandom};
                    endcase
                    set_ch(c, $urandom_range(0, 7) != 0, ChangeMode_e'($urandom_range(0, 3)), mk,
                           ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 5)));
                end
            end
            clr = '0;
            for (int c = 0; c < NUM_CH; c++) clr[c] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) != 0) bus = {$urandom, $urandom} & 64'h0000_0000_0000_01FF;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
